fc_layer_sequencer: RTL and testbench

FC_LAYER_SEQUENCER -- requirements
Module: fc_layer_sequencer

---
 rtl/fc_layer_sequencer_pkg.sv | 30 +++
 rtl/fc_layer_sequencer_if.sv | 35 +++
 rtl/fc_layer_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_layer_sequencer_pkg.sv
// Shared types and constants for the fully-connected layer sequencer and its MAC bus.
package fc_layer_sequencer_pkg;

  localparam int unsigned MAC_RES_W = 26;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [3:0] {
    StIdle,
    StFlush,
    StFetch,
    StIssue,
    StWait,
    StCapture,
    StBias,
    StWrite,
    StFinish
  } state_e;

  // Byte-lane mask for the final word of an input vector of the given length.
  function automatic logic [NUM_LANES-1:0] last_mask(input logic [1:0] tail);
    case (tail)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Bus between the layer sequencer (master) and the MAC controller (slave).
interface fc_layer_sequencer_if;
  import fc_layer_sequencer_pkg::*;

  logic                        mac_en;
  logic                        mac_flush;
  logic                        mac_bias_add;
  logic                        mac_relu;
  logic [NUM_LANES-1:0]        mac_valid;
  logic [DATA_W-1:0]           mac_feature;
  logic [DATA_W-1:0]           mac_weight;
  logic [DATA_W-1:0]           mac_bias;
  logic signed [MAC_RES_W-1:0] mac_result0;
  logic signed [MAC_RES_W-1:0] mac_result1;
  logic signed [MAC_RES_W-1:0] mac_result2;
  logic signed [MAC_RES_W-1:0] mac_result3;
  logic signed [MAC_RES_W-1:0] mac_out_result;
  logic                        mac_done;
  logic [DATA_W-1:0]           mac_out_data;

  modport master (
    output mac_en, mac_flush, mac_bias_add, mac_relu, mac_valid,
    output mac_feature, mac_weight, mac_bias,
    output mac_result0, mac_result1, mac_result2, mac_result3,
    input  mac_out_result, mac_done, mac_out_data
  );

  modport slave (
    input  mac_en, mac_flush, mac_bias_add, mac_relu, mac_valid,
    input  mac_feature, mac_weight, mac_bias,
    input  mac_result0, mac_result1, mac_result2, mac_result3,
    output mac_out_result, mac_done, mac_out_data
  );

endinterface

// File: rtl/fc_layer_sequencer.sv
// Sequences one FC layer: per neuron flush + word-by-word MAC issue, then per
// group of four neurons a bias/activation pass and one output-memory write.
module fc_layer_sequencer
  import fc_layer_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 relu_cfg,
  input  logic [ADDR_W-1:0]    in_bytes,
  input  logic [ADDR_W-1:0]    num_groups,
  output logic [ADDR_W-1:0]    feat_addr,
  input  logic [DATA_W-1:0]    feat_rdata,
  output logic [ADDR_W-1:0]    wgt_addr,
  input  logic [DATA_W-1:0]    wgt_rdata,
  output logic [ADDR_W-1:0]    bias_addr,
  input  logic [DATA_W-1:0]    bias_rdata,
  fc_layer_sequencer_if.master mac,
  output logic                 out_we,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [DATA_W-1:0]    out_wdata,
  output logic                 busy,
  output logic                 done
);

  state_e                      state_q;
  logic [ADDR_W-1:0]           k_q, g_q, wptr_q, last_k_q, last_g_q;
  logic [1:0]                  n_q;
  logic [NUM_LANES-1:0]        mask_q, valid_q;
  logic                        en_q, flush_q, bias_add_q, relu_q, bias_wait_q;
  logic signed [MAC_RES_W-1:0] res_q [NUM_LANES];
  logic [ADDR_W-1:0]           in_words;

  assign in_words = ADDR_W'(({1'b0, in_bytes} + (ADDR_W + 1)'(3)) >> 2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      k_q         <= '0;
      g_q         <= '0;
      n_q         <= '0;
      wptr_q      <= '0;
      last_k_q    <= '0;
      last_g_q    <= '0;
      mask_q      <= '0;
      valid_q     <= '0;
      en_q        <= 1'b0;
      flush_q     <= 1'b0;
      bias_add_q  <= 1'b0;
      relu_q      <= 1'b0;
      bias_wait_q <= 1'b0;
      feat_addr   <= '0;
      wgt_addr    <= '0;
      bias_addr   <= '0;
      out_we      <= 1'b0;
      out_addr    <= '0;
      out_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) res_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            k_q      <= '0;
            n_q      <= '0;
            g_q      <= '0;
            wptr_q   <= '0;
            last_k_q <= in_words - ADDR_W'(1);
            last_g_q <= num_groups - ADDR_W'(1);
            mask_q   <= last_mask(in_bytes[1:0]);
            if (in_bytes == '0 || num_groups == '0) begin
              state_q <= StFinish;
              done    <= 1'b1;
            end else begin
              state_q <= StFlush;
              busy    <= 1'b1;
              relu_q  <= relu_cfg;
              en_q    <= 1'b1;
              flush_q <= 1'b1;
            end
          end
        end
        StFlush: begin
          // The strobe cycle itself never counts as completion.
          if (flush_q) begin
            en_q    <= 1'b0;
            flush_q <= 1'b0;
          end else if (mac.mac_done) begin
            state_q   <= StFetch;
            feat_addr <= k_q;
            wgt_addr  <= wptr_q;
          end
        end
        StFetch: begin
          state_q <= StIssue;
          en_q    <= 1'b1;
          valid_q <= (k_q == last_k_q) ? mask_q : '1;
        end
        StIssue: begin
          state_q <= StWait;
          valid_q <= '0;
        end
        StWait: begin
          if (mac.mac_done) begin
            en_q   <= 1'b0;
            wptr_q <= wptr_q + ADDR_W'(1);
            if (k_q != last_k_q) begin
              k_q       <= k_q + ADDR_W'(1);
              feat_addr <= k_q + ADDR_W'(1);
              wgt_addr  <= wptr_q + ADDR_W'(1);
              state_q   <= StFetch;
            end else begin
              state_q <= StCapture;
            end
          end
        end
        StCapture: begin
          res_q[n_q] <= mac.mac_out_result;
          if (n_q != 2'd3) begin
            n_q     <= n_q + 2'd1;
            k_q     <= '0;
            state_q <= StFlush;
            en_q    <= 1'b1;
            flush_q <= 1'b1;
          end else begin
            state_q     <= StBias;
            bias_addr   <= g_q;
            bias_wait_q <= 1'b0;
          end
        end
        StBias: begin
          // Address cycle, then strobe cycle (bias word now valid), then wait.
          if (!bias_wait_q && !bias_add_q) begin
            en_q       <= 1'b1;
            bias_add_q <= 1'b1;
          end else if (bias_add_q) begin
            en_q        <= 1'b0;
            bias_add_q  <= 1'b0;
            bias_wait_q <= 1'b1;
          end else if (mac.mac_done) begin
            state_q     <= StWrite;
            bias_wait_q <= 1'b0;
            out_we      <= 1'b1;
            out_addr    <= g_q;
            out_wdata   <= mac.mac_out_data;
          end
        end
        StWrite: begin
          out_we <= 1'b0;
          if (g_q != last_g_q) begin
            g_q     <= g_q + ADDR_W'(1);
            n_q     <= '0;
            k_q     <= '0;
            state_q <= StFlush;
            en_q    <= 1'b1;
            flush_q <= 1'b1;
          end else begin
            state_q <= StFinish;
            done    <= 1'b1;
            busy    <= 1'b0;
            relu_q  <= 1'b0;
          end
        end
        StFinish: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mac.mac_en       = en_q;
  assign mac.mac_flush    = flush_q;
  assign mac.mac_bias_add = bias_add_q;
  assign mac.mac_relu     = relu_q;
  assign mac.mac_valid    = valid_q;
  // Read data is only forwarded during its own strobe so idle buses stay at zero.
  assign mac.mac_feature  = (|valid_q) ? feat_rdata : '0;
  assign mac.mac_weight   = (|valid_q) ? wgt_rdata : '0;
  assign mac.mac_bias     = bias_add_q ? bias_rdata : '0;
  assign mac.mac_result0  = res_q[0];
  assign mac.mac_result1  = res_q[1];
  assign mac.mac_result2  = res_q[2];
  assign mac.mac_result3  = res_q[3];

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: memories, a MAC controller model and a layer-level reference.
module tb_fc_layer_sequencer;

  localparam int AW = 8;

  logic          clk, rstn, start, relu_cfg;
  logic [AW-1:0] in_bytes, num_groups;
  logic [AW-1:0] feat_addr, wgt_addr, bias_addr, out_addr;
  logic [31:0]   feat_rdata, wgt_rdata, bias_rdata, out_wdata;
  logic          out_we, busy, done;

  fc_layer_sequencer_if mac_bus ();

  fc_layer_sequencer #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .relu_cfg   (relu_cfg),
    .in_bytes   (in_bytes),
    .num_groups (num_groups),
    .feat_addr  (feat_addr),
    .feat_rdata (feat_rdata),
    .wgt_addr   (wgt_addr),
    .wgt_rdata  (wgt_rdata),
    .bias_addr  (bias_addr),
    .bias_rdata (bias_rdata),
    .mac        (mac_bus),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_wdata  (out_wdata),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories with 1-cycle synchronous read.
  logic [31:0] fmem [256];
  logic [31:0] wmem [256];
  logic [31:0] bmem [256];
  always @(posedge clk) begin
    feat_rdata <= fmem[feat_addr];
    wgt_rdata  <= wmem[wgt_addr];
    bias_rdata <= bmem[bias_addr];
  end

  function automatic int sb(input logic [31:0] w, input int i);
    logic signed [7:0] b;
    b = w[8*i +: 8];
    return int'(b);
  endfunction

  function automatic logic [7:0] post(input int dot, input int b, input bit relu);
    int x;
    x = dot + b;
    if (relu && x < 0) x = 0;
    return x[7:0];
  endfunction

  function automatic int mac_sum(input logic [3:0] v, input logic [31:0] f, input logic [31:0] w);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) if (v[i]) s += sb(f, i) * sb(w, i);
    return s;
  endfunction

  function automatic logic [31:0] pack_out(input int r0, input int r1, input int r2, input int r3,
                                           input logic [31:0] b, input bit relu);
    logic [31:0] w;
    w[7:0]   = post(r0, sb(b, 0), relu);
    w[15:8]  = post(r1, sb(b, 1), relu);
    w[23:16] = post(r2, sb(b, 2), relu);
    w[31:24] = post(r3, sb(b, 3), relu);
    return w;
  endfunction

  // MAC controller model: any strobe completes mac_lat cycles later.
  logic signed [25:0] acc;
  logic [31:0]        odata;
  logic               mdone;
  int                 cnt;
  int                 mac_lat = 1;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc   <= '0;
      odata <= '0;
      mdone <= 1'b0;
      cnt   <= 0;
    end else begin
      mdone <= 1'b0;
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) mdone <= 1'b1;
      end
      if (mac_bus.mac_en && (mac_bus.mac_flush || mac_bus.mac_bias_add || mac_bus.mac_valid != 0))
      begin
        if (mac_bus.mac_flush) acc <= '0;
        else if (mac_bus.mac_valid != 0)
          acc <= acc + 26'(mac_sum(mac_bus.mac_valid, mac_bus.mac_feature, mac_bus.mac_weight));
        else
          odata <= pack_out(int'(mac_bus.mac_result0), int'(mac_bus.mac_result1),
                            int'(mac_bus.mac_result2), int'(mac_bus.mac_result3),
                            mac_bus.mac_bias, mac_bus.mac_relu);
        if (mac_lat <= 1) mdone <= 1'b1;
        else cnt <= mac_lat - 1;
      end
    end
  end
  assign mac_bus.mac_done       = mdone;
  assign mac_bus.mac_out_result = acc;
  assign mac_bus.mac_out_data   = odata;

  // Observation logs.
  int          wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wgt_q [$];
  int          feat_q [$];
  logic [3:0]  vld_q [$];
  int          bias_q [$];
  int          en_cnt, done_cnt, done_cyc, strobe_viol, relu_bad;
  bit          cur_relu;

  always @(negedge clk) begin
    int s;
    s = int'(mac_bus.mac_flush) + int'(mac_bus.mac_bias_add) + int'(mac_bus.mac_valid != 0);
    if (out_we) begin
      wr_addr_q.push_back(int'(out_addr));
      wr_data_q.push_back(out_wdata);
    end
    if (mac_bus.mac_valid != 0) begin
      wgt_q.push_back(int'(wgt_addr));
      feat_q.push_back(int'(feat_addr));
      vld_q.push_back(mac_bus.mac_valid);
      if (mac_bus.mac_relu != cur_relu) relu_bad++;
    end
    if (mac_bus.mac_bias_add) bias_q.push_back(int'(bias_addr));
    if (mac_bus.mac_en) en_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s > 1 || (s > 0 && !mac_bus.mac_en)) strobe_viol++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {busy, done, out_we, mac_bus.mac_en, mac_bus.mac_flush,
          mac_bus.mac_bias_add, mac_bus.mac_relu, mac_bus.mac_valid,
          feat_addr, wgt_addr, bias_addr, out_addr}, 64'd0);
    check({tag, "_data"}, {out_wdata, mac_bus.mac_bias | mac_bus.mac_feature | mac_bus.mac_weight},
          64'd0);
    check({tag, "_res"}, 64'(mac_bus.mac_result0 | mac_bus.mac_result1 | mac_bus.mac_result2 |
          mac_bus.mac_result3), 64'd0);
  endtask

  // Reference output word for group g, straight from the memory images.
  function automatic logic [31:0] ref_word(input int g, input int ib, input bit relu);
    logic [31:0] w;
    int iw, m, dot;
    iw = (ib + 3) / 4;
    for (int j = 0; j < 4; j++) begin
      m   = 4 * g + j;
      dot = 0;
      for (int b = 0; b < ib; b++) dot += sb(fmem[b / 4], b % 4) * sb(wmem[m * iw + b / 4], b % 4);
      w[8*j +: 8] = post(dot, sb(bmem[g], j), relu);
    end
    return w;
  endfunction

  typedef struct {
    int          ib;
    int          ng;
    bit          relu;
    int          lat;
    bit          ones;
    bit          restart;
    int          exp_writes;
    int          exp_wreads;
    logic [3:0]  exp_mask;
    logic [31:0] exp_data0;
  } vec_t;

  task automatic fill(input bit ones);
    for (int i = 0; i < 256; i++) begin
      fmem[i] = ones ? 32'h0101_0101 : $urandom;
      wmem[i] = ones ? 32'h0101_0101 : $urandom;
      bmem[i] = ones ? 32'h0 : $urandom;
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wgt_q.delete(); feat_q.delete();
    vld_q.delete(); bias_q.delete();
    en_cnt = 0; done_cnt = 0; done_cyc = -1; strobe_viol = 0; relu_bad = 0;
  endtask

  task automatic run_and_check(input vec_t v, input string tag);
    int t0, iw, bad;
    bit active;
    active = (v.ib != 0 && v.ng != 0);
    iw = (v.ib + 3) / 4;
    fill(v.ones);
    mac_lat = v.lat;
    cur_relu = v.relu;
    clear_logs();
    @(negedge clk);
    in_bytes = AW'(v.ib); num_groups = AW'(v.ng); relu_cfg = v.relu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    relu_cfg = ~v.relu;
    t0 = cyc;
    check({tag, " busy_at_start"}, busy, active);
    if (v.restart) begin
      repeat (6) @(negedge clk);
      in_bytes = AW'(v.ib + 4); start = 1'b1;
      @(negedge clk);
      start = 1'b0; in_bytes = AW'(v.ib);
    end
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(negedge clk);
    check({tag, " done_seen"}, done_cnt > 0, 1'b1);
    repeat (3) @(negedge clk);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " busy_after"}, busy, 0);
    if (!active) begin
      check({tag, " done_latency"}, done_cyc - t0, 0);
      check({tag, " mac_en_cycles"}, en_cnt, 0);
    end
    check({tag, " wr_count"}, wr_addr_q.size(), v.exp_writes);
    for (int i = 0; i < wr_addr_q.size() && i < v.exp_writes; i++) begin
      check($sformatf("%s wr_addr[%0d]", tag, i), wr_addr_q[i], i);
      check($sformatf("%s wr_data[%0d]", tag, i), wr_data_q[i], ref_word(i, v.ib, v.relu));
    end
    if (v.ones && wr_data_q.size() > 0) begin
      check({tag, " ones_data"}, wr_data_q[0], v.exp_data0);
      check({tag, " res01"}, {mac_bus.mac_result0, mac_bus.mac_result1}, {26'sd4, 26'sd4});
      check({tag, " res23"}, {mac_bus.mac_result2, mac_bus.mac_result3}, {26'sd4, 26'sd4});
    end
    check({tag, " wgt_reads"}, wgt_q.size(), v.exp_wreads);
    bad = -1;
    for (int i = wgt_q.size() - 1; i >= 0; i--) begin
      if (wgt_q[i] != i || feat_q[i] != i % iw) bad = i;
      if (vld_q[i] != ((i % iw == iw - 1) ? v.exp_mask : 4'hF)) bad = i;
    end
    check({tag, " issue_seq_first_bad"}, bad, -1);
    check({tag, " bias_count"}, bias_q.size(), v.exp_writes);
    bad = -1;
    for (int i = bias_q.size() - 1; i >= 0; i--) if (bias_q[i] != i) bad = i;
    check({tag, " bias_seq_first_bad"}, bad, -1);
    check({tag, " strobe_viol"}, strobe_viol, 0);
    check({tag, " relu_bad"}, relu_bad, 0);
  endtask

  vec_t tbl [8];

  initial begin
    vec_t v;
    int n_wr;
    tbl[0] = '{4, 1, 1'b0, 1, 1'b1, 1'b0, 1, 4,  4'hF, 32'h0404_0404};
    tbl[1] = '{6, 1, 1'b0, 1, 1'b0, 1'b0, 1, 8,  4'h3, 32'h0};
    tbl[2] = '{8, 3, 1'b0, 1, 1'b0, 1'b0, 3, 24, 4'hF, 32'h0};
    tbl[3] = '{0, 2, 1'b0, 1, 1'b0, 1'b0, 0, 0,  4'h0, 32'h0};
    tbl[4] = '{5, 0, 1'b0, 1, 1'b0, 1'b0, 0, 0,  4'h0, 32'h0};
    tbl[5] = '{3, 2, 1'b1, 2, 1'b0, 1'b0, 2, 8,  4'h7, 32'h0};
    tbl[6] = '{9, 2, 1'b1, 3, 1'b0, 1'b1, 2, 24, 4'h1, 32'h0};
    tbl[7] = '{7, 1, 1'b0, 2, 1'b0, 1'b1, 1, 8,  4'h7, 32'h0};

    rstn = 1'b0; start = 1'b0; relu_cfg = 1'b0; in_bytes = '0; num_groups = '0;
    cur_relu = 1'b0;
    fill(1'b0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_and_check(tbl[i], $sformatf("vec%0d", i));

    // Reset during WAIT of group 1, then a fresh layer.
    fill(1'b0);
    clear_logs();
    mac_lat = 2;
    cur_relu = 1'b0;
    in_bytes = 8'd8; num_groups = 8'd2; relu_cfg = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && wr_addr_q.size() == 0; i++) @(negedge clk);
    check("rst_group0_written", wr_addr_q.size(), 1);
    for (int i = 0; i < 2000 && !(mac_bus.mac_en && mac_bus.mac_valid == 0 && !mac_bus.mac_flush
         && !mac_bus.mac_bias_add); i++) @(negedge clk);
    check("rst_in_wait", {mac_bus.mac_en, mac_bus.mac_flush, mac_bus.mac_bias_add}, 3'b100);
    #2 rstn = 1'b0;
    #1 check_zero("midrun_reset");
    n_wr = wr_addr_q.size();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_no_write", wr_addr_q.size(), n_wr);
    check("rst_idle_busy", busy, 0);
    check("rst_no_done", done_cnt, 0);
    v = '{8, 2, 1'b0, 1, 1'b0, 1'b0, 2, 16, 4'hF, 32'h0};
    run_and_check(v, "post_reset");

    for (int r = 0; r < 8; r++) begin
      v.ib = $urandom_range(1, 20);
      v.ng = $urandom_range(1, 3);
      v.relu = 1'($urandom_range(0, 1));
      v.lat = $urandom_range(1, 3);
      v.ones = 1'b0;
      v.restart = 1'($urandom_range(0, 1));
      v.exp_writes = v.ng;
      v.exp_wreads = 4 * v.ng * ((v.ib + 3) / 4);
      v.exp_mask = (v.ib % 4 == 0) ? 4'hF : 4'((1 << (v.ib % 4)) - 1);
      v.exp_data0 = 32'h0;
      run_and_check(v, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
